// File: rtl/ov5640_dvp_tx.sv
// OV5640-style DVP transmitter: turns a FIFO of RGB565 pixels into vsync/href/byte
// framing, two bytes per pixel (high byte first), with one-pixel read prefetch.
module ov5640_dvp_tx #(
    parameter int H_PIXEL  = 640,
    parameter int H_BLANK  = 160,
    parameter int VS_LINES = 2,
    parameter int V_BP     = 16,
    parameter int V_LINE   = 480,
    parameter int V_FP     = 8
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        tx_en,
    output logic        pix_rd_en,
    input  logic [15:0] pix_data,
    input  logic        pix_empty,
    output logic        dvp_vsync,
    output logic        dvp_href,
    output logic [7:0]  dvp_data,
    output logic        frame_done,
    output logic        pix_underflow
);

    localparam int LINE_CYC = 2 * H_PIXEL + H_BLANK;

    localparam logic [11:0] H_LAST   = 12'(LINE_CYC - 1);
    localparam logic [11:0] PRE_H    = 12'(LINE_CYC - 2);
    localparam logic [11:0] HREF_LEN = 12'(2 * H_PIXEL);
    localparam logic [11:0] RD_LIM   = 12'(2 * H_PIXEL - 2);
    localparam logic [11:0] VS_LAST  = 12'(VS_LINES - 1);
    localparam logic [11:0] VBP_LAST = 12'((V_BP > 0) ? V_BP - 1 : 0);
    localparam logic [11:0] ACT_LAST = 12'(V_LINE - 1);
    localparam logic [11:0] VFP_LAST = 12'((V_FP > 0) ? V_FP - 1 : 0);
    localparam logic        VS_TO_ACT = (V_BP == 0);
    localparam logic        HAS_VFP   = (V_FP > 0);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_VS   = 3'd1,
        ST_VBP  = 3'd2,
        ST_ACT  = 3'd3,
        ST_VFP  = 3'd4
    } state_t;

    state_t      state_r, state_nxt_s, follow_s;
    logic [11:0] h_cnt_r, h_nxt_s;
    logic [11:0] v_cnt_r, v_nxt_s;
    logic [11:0] v_last_s;

    logic        vsync_r, href_r, rd_en_r, done_r, underflow_r;
    logic [7:0]  data_r;
    logic        rd_d1_r, empty_r;
    logic [15:0] pix_word_r;

    logic        href_nxt_s, rd_nxt_s, done_nxt_s, next_act_line_s;
    logic [7:0]  data_nxt_s;
    logic [15:0] word_s;

    // Line count of the current state and the state that follows it (zero-line states skipped).
    always_comb begin
        v_last_s = 12'd0;
        follow_s = ST_IDLE;
        case (state_r)
            ST_VS: begin
                v_last_s = VS_LAST;
                follow_s = VS_TO_ACT ? ST_ACT : ST_VBP;
            end
            ST_VBP: begin
                v_last_s = VBP_LAST;
                follow_s = ST_ACT;
            end
            ST_ACT: begin
                v_last_s = ACT_LAST;
                follow_s = HAS_VFP ? ST_VFP : (tx_en ? ST_VS : ST_IDLE);
            end
            ST_VFP: begin
                v_last_s = VFP_LAST;
                follow_s = tx_en ? ST_VS : ST_IDLE;
            end
            default: begin
                v_last_s = 12'd0;
                follow_s = ST_IDLE;
            end
        endcase
    end

    // Next-state and counter update; state changes only when h_cnt wraps.
    always_comb begin
        state_nxt_s = state_r;
        h_nxt_s     = h_cnt_r;
        v_nxt_s     = v_cnt_r;
        if (state_r == ST_IDLE) begin
            h_nxt_s = 12'd0;
            v_nxt_s = 12'd0;
            if (tx_en) begin
                state_nxt_s = ST_VS;
            end else begin
                state_nxt_s = ST_IDLE;
            end
        end else if (h_cnt_r == H_LAST) begin
            h_nxt_s = 12'd0;
            if (v_cnt_r == v_last_s) begin
                v_nxt_s     = 12'd0;
                state_nxt_s = follow_s;
            end else begin
                v_nxt_s = v_cnt_r + 12'd1;
            end
        end else begin
            h_nxt_s = h_cnt_r + 12'd1;
        end
    end

    // Output decode from the next position so every pin is a plain flop.
    always_comb begin
        next_act_line_s = 1'b0;
        case (state_nxt_s)
            ST_VS:   next_act_line_s = VS_TO_ACT && (v_nxt_s == VS_LAST);
            ST_VBP:  next_act_line_s = (v_nxt_s == VBP_LAST);
            ST_ACT:  next_act_line_s = (v_nxt_s != ACT_LAST);
            default: next_act_line_s = 1'b0;
        endcase

        href_nxt_s = (state_nxt_s == ST_ACT) && (h_nxt_s < HREF_LEN);
        rd_nxt_s   = ((state_nxt_s == ST_ACT) && !h_nxt_s[0] && (h_nxt_s < RD_LIM)) ||
                     ((h_nxt_s == PRE_H) && next_act_line_s);
        if (HAS_VFP) begin
            done_nxt_s = (state_nxt_s == ST_VFP) && (v_nxt_s == VFP_LAST) && (h_nxt_s == H_LAST);
        end else begin
            done_nxt_s = (state_nxt_s == ST_ACT) && (v_nxt_s == ACT_LAST) && (h_nxt_s == H_LAST);
        end

        // A read that saw an empty FIFO delivers a black pixel instead of FIFO garbage.
        word_s = rd_d1_r ? (empty_r ? 16'h0000 : pix_data) : pix_word_r;
        if (href_nxt_s) begin
            data_nxt_s = h_nxt_s[0] ? pix_word_r[7:0] : word_s[15:8];
        end else begin
            data_nxt_s = 8'h00;
        end
    end

    // Frame state and position counters.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_r <= ST_IDLE;
            h_cnt_r <= 12'd0;
            v_cnt_r <= 12'd0;
        end else begin
            state_r <= state_nxt_s;
            h_cnt_r <= h_nxt_s;
            v_cnt_r <= v_nxt_s;
        end
    end

    // Registered DVP pins, read strobe and frame pulse.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            vsync_r <= 1'b0;
            href_r  <= 1'b0;
            data_r  <= 8'h00;
            rd_en_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            vsync_r <= (state_nxt_s == ST_VS);
            href_r  <= href_nxt_s;
            data_r  <= data_nxt_s;
            rd_en_r <= rd_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    // Pixel capture pipeline and sticky underflow flag.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rd_d1_r     <= 1'b0;
            empty_r     <= 1'b0;
            pix_word_r  <= 16'h0000;
            underflow_r <= 1'b0;
        end else begin
            rd_d1_r     <= rd_en_r;
            empty_r     <= rd_en_r & pix_empty;
            pix_word_r  <= word_s;
            underflow_r <= underflow_r | (rd_en_r & pix_empty);
        end
    end

    assign pix_rd_en     = rd_en_r;
    assign dvp_vsync     = vsync_r;
    assign dvp_href      = href_r;
    assign dvp_data      = data_r;
    assign frame_done    = done_r;
    assign pix_underflow = underflow_r;

endmodule

// File: tb/tb_ov5640_dvp_tx.sv
// Bench for ov5640_dvp_tx: two instances (with and without blank-line states), a FIFO
// responder and a frame-geometry reference model checked every cycle.
module tb_ov5640_dvp_tx;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        tx_en_a, tx_en_z, pix_empty_a, pix_empty_z;
    logic [15:0] pix_data_a, pix_data_z;
    logic        rd_a, vs_a, hr_a, fd_a, uf_a;
    logic        rd_z, vs_z, hr_z, fd_z, uf_z;
    logic [7:0]  dt_a, dt_z;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] pix_mem [64];
    logic        uf_exp [2];

    always #5 sys_clk = ~sys_clk;

    ov5640_dvp_tx #(.H_PIXEL(4), .H_BLANK(3), .VS_LINES(1), .V_BP(1), .V_LINE(2), .V_FP(1)) dut_a (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .tx_en(tx_en_a), .pix_rd_en(rd_a),
        .pix_data(pix_data_a), .pix_empty(pix_empty_a), .dvp_vsync(vs_a), .dvp_href(hr_a),
        .dvp_data(dt_a), .frame_done(fd_a), .pix_underflow(uf_a));

    ov5640_dvp_tx #(.H_PIXEL(4), .H_BLANK(3), .VS_LINES(1), .V_BP(0), .V_LINE(2), .V_FP(0)) dut_z (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .tx_en(tx_en_z), .pix_rd_en(rd_z),
        .pix_data(pix_data_z), .pix_empty(pix_empty_z), .dvp_vsync(vs_z), .dvp_href(hr_z),
        .dvp_data(dt_z), .frame_done(fd_z), .pix_underflow(uf_z));

    task automatic chk(input string tag, input int c, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, c, obs, exp);
        end
    endtask

    // Frame length in cycles: VS_LINES=1, V_LINE=2, V_BP=V_FP=1 (dut_a) or 0 (dut_z), 11 cycles/line.
    function automatic int frame_len(input int which);
        return (which == 0) ? 55 : 33;
    endfunction

    // Byte index within the phase's pixel stream carried at cycle c, or -1 when href is low.
    // Cycle 0 is the cycle in which tx_en is first sampled; frames start at cycle 1.
    function automatic int byte_pos(input int c, input int which, input int nfr);
        int vbp, fl, f, in_f, line, h, al;
        vbp = (which == 0) ? 1 : 0;
        fl  = frame_len(which);
        if (c < 1) return -1;
        f = c - 1;
        if (f / fl >= nfr) return -1;
        in_f = f % fl;
        line = in_f / 11;
        h    = in_f % 11;
        al   = line - 1 - vbp;
        if (al < 0 || al >= 2 || h >= 8) return -1;
        return ((f / fl) * 2 + al) * 8 + h;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_vs_a"}, -1, {15'd0, vs_a}, 16'd0);
        chk({tag, "_hr_a"}, -1, {15'd0, hr_a}, 16'd0);
        chk({tag, "_dt_a"}, -1, {8'd0, dt_a}, 16'd0);
        chk({tag, "_rd_a"}, -1, {15'd0, rd_a}, 16'd0);
        chk({tag, "_fd_a"}, -1, {15'd0, fd_a}, 16'd0);
        chk({tag, "_uf_a"}, -1, {15'd0, uf_a}, 16'd0);
        chk({tag, "_vs_z"}, -1, {15'd0, vs_z}, 16'd0);
        chk({tag, "_hr_z"}, -1, {15'd0, hr_z}, 16'd0);
    endtask

    // One directed phase: raise tx_en at cycle 0, drop it at drop_cyc, act as the FIFO,
    // and compare every output against the model for ncyc cycles.
    task automatic run_phase(input int which, input int ncyc, input int nfr, input int force_rd,
                             input int drop_cyc, input int exp_rd_total);
        int          rdn, rd_seen, b, bn, p, f, fl;
        logic        ov, oh, ord, ofd, ouf, emp_now, ev, eh, erd, efd;
        logic [7:0]  od, ed;
        logic [15:0] val;
        rdn = 0;
        rd_seen = 0;
        fl = frame_len(which);
        if (which == 0) begin tx_en_a = 1'b1; pix_empty_a = (force_rd == 0); end
        else begin tx_en_z = 1'b1; pix_empty_z = (force_rd == 0); end
        for (int c = 0; c < ncyc; c++) begin
            if (c == drop_cyc) begin
                if (which == 0) tx_en_a = 1'b0; else tx_en_z = 1'b0;
            end
            @(negedge sys_clk);
            ov  = which ? vs_z : vs_a;   oh  = which ? hr_z : hr_a;
            od  = which ? dt_z : dt_a;   ord = which ? rd_z : rd_a;
            ofd = which ? fd_z : fd_a;   ouf = which ? uf_z : uf_a;
            emp_now = which ? pix_empty_z : pix_empty_a;

            f   = c - 1;
            ev  = (c >= 1) && (f / fl < nfr) && (f % fl < 11);
            efd = (c >= 1) && (f / fl < nfr) && (f % fl == fl - 1);
            b   = byte_pos(c, which, nfr);
            eh  = (b >= 0);
            ed  = 8'h00;
            if (b >= 0) begin
                p   = b / 2;
                val = (p == force_rd) ? 16'h0000 : pix_mem[p];
                ed  = (b % 2 == 1) ? val[7:0] : val[15:8];
            end
            bn  = byte_pos(c + 2, which, nfr);
            erd = (bn >= 0) && (bn % 2 == 0);

            chk("vsync", c, {15'd0, ov}, {15'd0, ev});
            chk("href", c, {15'd0, oh}, {15'd0, eh});
            chk("data", c, {8'd0, od}, {8'd0, ed});
            chk("rd_en", c, {15'd0, ord}, {15'd0, erd});
            chk("frame_done", c, {15'd0, ofd}, {15'd0, efd});
            chk("underflow", c, {15'd0, ouf}, {15'd0, uf_exp[which]});
            if (erd && (bn / 2 == force_rd)) uf_exp[which] = 1'b1;
            if (ord) rd_seen++;

            @(posedge sys_clk);
            #1;
            if (ord) begin
                if (which == 0) pix_data_a = emp_now ? 16'($urandom) : pix_mem[rdn];
                else            pix_data_z = emp_now ? 16'($urandom) : pix_mem[rdn];
                rdn++;
                if (which == 0) pix_empty_a = (rdn == force_rd);
                else            pix_empty_z = (rdn == force_rd);
            end
        end
        if (exp_rd_total >= 0) chk("rd_count", ncyc, 16'(rd_seen), 16'(exp_rd_total));
    endtask

    task automatic fill_random();
        for (int i = 0; i < 64; i++) pix_mem[i] = 16'($urandom);
    endtask

    initial begin
        sys_rst = 1'b1;
        tx_en_a = 1'b0; tx_en_z = 1'b0;
        pix_empty_a = 1'b0; pix_empty_z = 1'b0;
        pix_data_a = 16'h0000; pix_data_z = 16'h0000;
        uf_exp[0] = 1'b0; uf_exp[1] = 1'b0;

        // Reset state
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check_all_zero("reset");
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;

        // Basic frames: first eight pixels A001..A008, back-to-back second frame
        fill_random();
        for (int i = 0; i < 8; i++) pix_mem[i] = 16'hA001 + 16'(i);
        run_phase(0, 120, 2, -1, 55 + 20, 16);

        // tx_en dropped at cycle 20, then reasserted
        fill_random();
        run_phase(0, 70, 1, -1, 20, 8);
        fill_random();
        run_phase(0, 60, 1, -1, 20, 8);

        // Zero-line VBP/VFP configuration
        fill_random();
        run_phase(1, 80, 2, -1, 33 + 20, 16);

        // Underflow on the third read
        fill_random();
        run_phase(0, 65, 1, 2, 20, 8);

        // Asynchronous reset while href is high, restart with tx_en held
        fill_random();
        run_phase(0, 25, 1, -1, -1, -1);
        #2;
        sys_rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        uf_exp[0] = 1'b0;
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        fill_random();
        run_phase(0, 60, 1, -1, 20, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
